// File: rtl/alu_pkg.sv
// Shared defaults, FSM encoding and ALU opcode constants for the ALU issue arbiter.
package alu_pkg;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefW    = 8;
  localparam int unsigned DefOpw  = 3;
  localparam int unsigned DefLat  = 3;

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  localparam logic [DefOpw-1:0] OpAdd  = 3'd0;
  localparam logic [DefOpw-1:0] OpSub  = 3'd1;
  localparam logic [DefOpw-1:0] OpAnd  = 3'd2;
  localparam logic [DefOpw-1:0] OpOr   = 3'd3;
  localparam logic [DefOpw-1:0] OpXor  = 3'd4;
  localparam logic [DefOpw-1:0] OpShl  = 3'd5;
  localparam logic [DefOpw-1:0] OpShr  = 3'd6;
  localparam logic [DefOpw-1:0] OpPass = 3'd7;

  // Requester-id width; a single requester still needs a 1-bit id.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index strictly above ptr_i, wrapping.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  localparam int unsigned IdW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o
);

  logic [IdW-1:0] idx;
  logic           found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    // Offset NREQ wraps back to ptr_i itself, so a lone requester can be re-granted.
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = IdW'((32'(ptr_i) + off) % NREQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arb.sv
// Arbitrates NREQ requesters onto one fixed-latency ALU and returns tagged results,
// with a RUN/DRAIN/HALT controller for emptying the pipeline.
module alu_issue_arb
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned W    = DefW,
  parameter int unsigned OPW  = DefOpw,
  parameter int unsigned LAT  = DefLat,
  localparam int unsigned IdW = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              alu_valid,
  output logic [OPW-1:0]    alu_op,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  input  logic [W-1:0]      alu_result,
  output logic              rsp_valid,
  output logic [IdW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_data,
  input  logic              drain_req,
  output logic              idle
);

  localparam int unsigned CntW = $clog2(LAT + 2);

  logic [1:0]      state_q, state_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] grant;
  logic            accept;
  logic [IdW-1:0]  grant_id;
  logic [OPW-1:0]  sel_op;
  logic [W-1:0]    sel_a, sel_b;

  logic            alu_valid_q;
  logic [OPW-1:0]  alu_op_q;
  logic [W-1:0]    alu_a_q, alu_b_q;
  logic [IdW-1:0]  alu_id_q;

  logic [LAT-1:0]  tag_vld_q;
  logic [IdW-1:0]  tag_id_q [LAT];
  logic            rsp_set;

  logic            rsp_valid_q;
  logic [IdW-1:0]  rsp_id_q;
  logic [W-1:0]    rsp_data_q;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign req_ready = (state_q == StRun) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    grant_id = '0;
    sel_op   = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id = IdW'(i);
        sel_op   = req_op[i*OPW +: OPW];
        sel_a    = req_a[i*W +: W];
        sel_b    = req_b[i*W +: W];
      end
    end
  end

  assign ptr_d = accept ? grant_id : ptr_q;

  // A tag leaving the last stage lines up with the ALU result for that op.
  assign rsp_set = tag_vld_q[LAT-1];

  always_comb begin
    unique case ({accept, rsp_set})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (drain_req) state_d = StDrain;
      end
      StDrain: begin
        if (!drain_req)          state_d = StRun;
        else if (cnt_q == '0)    state_d = StHalt;
      end
      StHalt: begin
        if (!drain_req) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      ptr_q   <= IdW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_id_q    <= '0;
    end else begin
      alu_valid_q <= accept;
      if (accept) begin
        alu_op_q <= sel_op;
        alu_a_q  <= sel_a;
        alu_b_q  <= sel_b;
        alu_id_q <= grant_id;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) tag_id_q[k] <= '0;
    end else begin
      tag_vld_q[0] <= alu_valid_q;
      tag_id_q[0]  <= alu_id_q;
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_set;
      if (rsp_set) begin
        rsp_id_q   <= tag_id_q[LAT-1];
        rsp_data_q <= alu_result;
      end
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign idle      = (state_q == StHalt) && (cnt_q == '0);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
  a_cnt_range:    assert property (@(posedge clk) disable iff (!reset)
                                   cnt_q <= CntW'(LAT + 1));

endmodule

// File: doc/alu_issue_arb.md
ALU_ISSUE_ARB -- requirements
Module: alu_issue_arb

Interface
Parameters:
REQ-001 SHALL have parameter NREQ, default 4: number of requesters.
REQ-002 SHALL have parameter W, default 8: operand and result width.
REQ-003 SHALL have parameter OPW, default 3: ALU opcode width.
REQ-004 SHALL have parameter LAT, default 3: fixed ALU pipeline latency in cycles, legal range 1..8.

Ports:
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, NREQ bits: per-requester op valid.
REQ-008 SHALL have port req_ready, output, NREQ bits: per-requester accept; at most one bit set.
REQ-009 SHALL have port req_op, input, NREQ*OPW bits: opcodes, requester i in slice i.
REQ-010 SHALL have port req_a and port req_b, input, NREQ*W bits each: operands, sliced per requester.
REQ-011 SHALL have ports alu_valid (1), alu_op (OPW), alu_a (W) and alu_b (W), all outputs: issue port to the ALU pipeline.
REQ-012 SHALL have port alu_result, input, W bits: ALU output, valid exactly LAT cycles after alu_valid is sampled.
REQ-013 SHALL have ports rsp_valid (1), rsp_id (clog2 NREQ) and rsp_data (W), all outputs: completed result and owning requester.
REQ-014 SHALL have port drain_req, input, 1 bit: stop accepting new ops and empty the pipeline.
REQ-015 SHALL have port idle, output, 1 bit: high when in HALT with nothing in flight.

Function
REQ-016 SHALL use round-robin arbitration: grant the lowest index strictly above the last-granted index (wrapping); after reset, search starts at index 0.
REQ-017 SHALL assert req_ready[i] combinationally only in state RUN, and only for the requester winning arbitration among req_valid.
REQ-018 SHALL accept an op on the edge where req_valid[i] and req_ready[i] are both high; only that accept updates the last-granted pointer.
REQ-019 SHALL, on an accept at edge T, register alu_valid=1 with the op and operands during cycle T+1; otherwise alu_valid=0 and alu_op/alu_a/alu_b hold their previous values.
REQ-020 SHALL track each issued op's requester id through a LAT-deep tag shift register advancing every cycle.
REQ-021 SHALL, when a tag reaches the end of the shift register, register rsp_valid=1, rsp_id=tag and rsp_data=alu_result, so the response is visible in cycle T+2+LAT.
REQ-022 SHALL keep rsp_valid low in all other cycles; rsp has no backpressure.
REQ-023 SHALL keep an in-flight counter of range 0..LAT+1: +1 on accept, -1 on rsp_valid set, net 0 when both occur on the same edge.
REQ-024 SHALL implement FSM state RUN: accepts allowed; go to DRAIN when drain_req=1.
REQ-025 SHALL implement FSM state DRAIN: no accepts; go to HALT when the in-flight count is 0; go back to RUN if drain_req drops first.
REQ-026 SHALL implement FSM state HALT: no accepts; idle=1; go to RUN when drain_req=0.
REQ-027 SHALL, when drain_req rises on the same edge as an accept, still complete that accept; the accepted op drains normally.
REQ-028 SHALL produce a result for every accepted op, in issue order, with no duplicates or drops, including back-to-back accepts on every cycle.

Reset
REQ-029 SHALL, while reset=0, clear immediately: FSM=RUN, pointer=NREQ-1 (so index 0 is searched first), tag shift register empty, in-flight count=0.
REQ-030 SHALL hold during reset: alu_valid=0, alu_op=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, idle=0.
REQ-031 SHALL discard all in-flight ops when reset is asserted mid-operation; no responses for them appear after release.

Structure
REQ-032 SHALL place the default values of NREQ, W, OPW and LAT, the FSM state encoding (RUN/DRAIN/HALT) and the ALU opcode constants in a shared package, alu_pkg.
REQ-033 SHALL implement the round-robin arbiter as one sub-module, rr_arbiter (inputs: request vector, last-grant pointer; output: one-hot grant).

Verification
REQ-034 SHALL cover a single op: req_valid=0001, op=ADD, a=5, b=3, accepted at edge T -> alu_valid in cycle T+1; rsp_valid=1, rsp_id=0, rsp_data=8 in cycle T+5 (LAT=3).
REQ-035 SHALL cover fairness: req_valid=1111 held for 8 accepts -> grant order 0,1,2,3,0,1,2,3; rsp_id order identical.
REQ-036 SHALL cover back-to-back issue: requester 2 issues 4 ops on consecutive cycles -> 4 consecutive rsp_valid cycles with ids all 2 and data in issue order.
REQ-037 SHALL cover drain: drain_req=1 with 3 ops in flight -> req_ready=0 at once; idle=1 in the cycle after the 3rd rsp; with drain_req=0, the next accept occurs in the following cycle.
REQ-038 SHALL cover reset mid-flight: reset=0 for 1 cycle with 2 ops in flight -> all outputs 0 immediately; no rsp_valid for 10 cycles after release.
REQ-039 SHALL cover simultaneous events: drain_req rises on an accepting edge -> that op's rsp still appears; FSM reaches HALT afterwards.
